// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the miniRISC datapath: fetch, decode, execute, memory, write-back.
// Owns the memory request/ack handshake with a bounded wait that traps on expiry.
module mc_control_unit #(
    parameter int unsigned Timeout = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_flag_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_src_imm_o,
    output logic        rf_we_o,
    output logic        wb_sel_o,
    output logic [2:0]  state_o,
    output logic        halted_o,
    output logic        trap_o,
    output logic [31:0] instr_count_o
);

    localparam int unsigned WaitW = $clog2(Timeout + 1);

    localparam logic [5:0] OpRAlu = 6'd0;
    localparam logic [5:0] OpIAlu = 6'd1;
    localparam logic [5:0] OpLd   = 6'd2;
    localparam logic [5:0] OpSt   = 6'd3;
    localparam logic [5:0] OpBr   = 6'd4;
    localparam logic [5:0] OpJ    = 6'd5;
    localparam logic [5:0] OpHalt = 6'd6;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StTrap   = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               retire;
    logic               wait_expired;

    // The request has used its last permitted cycle when wait_q reaches Timeout-1 without ack.
    assign wait_expired = (wait_q == WaitW'(Timeout - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack_i)         state_d = StDecode;
                else if (wait_expired) state_d = StTrap;
            end
            StDecode: begin
                op_d = opcode_i;
                case (opcode_i)
                    OpHalt: begin
                        state_d = StHalt;
                        retire  = 1'b1;
                    end
                    OpJ: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    OpRAlu, OpIAlu, OpLd, OpSt, OpBr: state_d = StExec;
                    default: state_d = StTrap;
                endcase
            end
            StExec: begin
                case (op_q)
                    OpRAlu, OpIAlu: state_d = StWb;
                    OpLd, OpSt:     state_d = StMem;
                    OpBr: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    default: state_d = StTrap;
                endcase
            end
            StMem: begin
                if (mem_ack_i) begin
                    if (op_q == OpLd) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt: state_d = StHalt;
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Staying in FETCH/MEM means no ack this cycle; any other move clears the counter.
        if ((state_q == StFetch || state_q == StMem) && state_d == state_q) begin
            wait_d = wait_q + WaitW'(1);
        end else begin
            wait_d = '0;
        end
        cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= 6'd0;
            wait_q  <= '0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        addr_sel_o    = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_src_o      = 2'd0;
        alu_src_imm_o = 1'b0;
        rf_we_o       = 1'b0;
        wb_sel_o      = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ack_i;
                pc_we_o   = mem_ack_i;
            end
            StDecode: begin
                if (opcode_i == OpJ) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = 2'd2;
                end
            end
            StExec: begin
                alu_src_imm_o = (op_q == OpIAlu) || (op_q == OpLd) || (op_q == OpSt);
                if (op_q == OpBr) begin
                    pc_we_o  = zero_flag_i;
                    pc_src_o = 2'd1;
                end
            end
            StMem: begin
                mem_req_o     = 1'b1;
                addr_sel_o    = 1'b1;
                mem_we_o      = (op_q == OpSt);
                alu_src_imm_o = 1'b1;
            end
            StWb: begin
                rf_we_o  = 1'b1;
                wb_sel_o = (op_q == OpLd);
            end
            default: ;
        endcase
    end

    assign state_o       = state_q;
    assign halted_o      = (state_q == StHalt);
    assign trap_o        = (state_q == StTrap);
    assign instr_count_o = cnt_q;

endmodule
